// File: rtl/dfp_divide_seq_pkg.sv
// Shared types and BCD helpers for the sequential decimal floating-point divider.
// The BCD helpers work on DIG_MAX-digit vectors; callers zero-extend narrower operands.
package dfp_divide_seq_pkg;

  localparam int DIG_MAX = 32;
  localparam int SIG_MAX = DIG_MAX * 4;

  typedef enum logic [1:0] {IDLE, NORM, DIV, FIN} dfp_div_state_t;

  typedef struct packed {
    logic invalid;
    logic divbyzero;
    logic overflow;
    logic underflow;
  } dfp_exc_t;

  // Outcome of the operand-class decode, held until FIN.
  typedef struct packed {
    logic special;
    logic nan;
    logic inf;
    logic zero;
    logic invalid;
    logic divbyzero;
  } dfp_special_t;

  function automatic logic [SIG_MAX-1:0] bcd_sub_n(input logic [SIG_MAX-1:0] a,
                                                   input logic [SIG_MAX-1:0] b);
    logic [SIG_MAX-1:0] res;
    logic borrow;
    logic [4:0] t;
    res = '0;
    borrow = 1'b0;
    for (int i = 0; i < DIG_MAX; i++) begin
      t = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'd0, borrow};
      if (t[4]) begin
        res[i*4 +: 4] = t[3:0] + 4'd10;
        borrow = 1'b1;
      end else begin
        res[i*4 +: 4] = t[3:0];
        borrow = 1'b0;
      end
    end
    return res;
  endfunction

  // Valid BCD digits keep positional order, so a plain unsigned compare suffices.
  function automatic logic bcd_ge_n(input logic [SIG_MAX-1:0] a,
                                    input logic [SIG_MAX-1:0] b);
    return a >= b;
  endfunction

endpackage

// File: rtl/dfp_lzc.sv
// Combinational leading-zero-digit counter for an N-digit BCD coefficient.
// An all-zero coefficient reports N.
module dfp_lzc #(
  parameter int N = 25,
  localparam int LZW = $clog2(N + 1)
) (
  input  logic [N*4-1:0] sig,
  output logic [LZW-1:0] lz
);

  always_comb begin
    lz = LZW'(N);
    for (int i = 0; i < N; i++) begin
      if (sig[i*4 +: 4] != 4'd0) lz = LZW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/dfp_divide_seq.sv
// Sequential radix-10 restoring divider for BCD significands; emits an unrounded
// N+G digit quotient with sticky for the downstream normalise/round stages.
module dfp_divide_seq
  import dfp_divide_seq_pkg::*;
#(
  parameter int N    = 25,
  parameter int G    = 2,
  parameter int EXPW = 12,
  parameter int BIAS = 'h5FF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   ld,
  input  logic                   a_sign,
  input  logic                   b_sign,
  input  logic [EXPW-1:0]        a_exp,
  input  logic [EXPW-1:0]        b_exp,
  input  logic [N*4-1:0]         a_sig,
  input  logic [N*4-1:0]         b_sig,
  input  logic                   a_nan,
  input  logic                   b_nan,
  input  logic                   a_inf,
  input  logic                   b_inf,
  output logic                   o_sign,
  output logic signed [EXPW+1:0] o_exp,
  output logic [(N+G)*4-1:0]     o_sig,
  output logic                   o_sticky,
  output logic                   o_nan,
  output logic                   o_inf,
  output logic                   o_zero,
  output logic                   invalid,
  output logic                   divbyzero,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   busy,
  output logic                   done,
  output dfp_div_state_t         dbg_state
);

  localparam int RW  = (N + 1) * 4;
  localparam int QD  = N + G + 1;
  localparam int QW  = QD * 4;
  localparam int OW  = (N + G) * 4;
  localparam int LZW = $clog2(N + 1);
  localparam int KW  = $clog2(QD + 1);

  // Handshake: ld is taken on any edge with ce=1 and always (re)starts an operation;
  // done is a level that drops with ld and rises together with the registered result.
  dfp_div_state_t state;
  dfp_special_t   spc, in_spc;
  dfp_exc_t       exc;
  logic [N*4-1:0] sa, sb;
  logic [EXPW-1:0] ea, eb;
  logic           sgn;
  logic [RW-1:0]  rem, dvs;
  logic [QW-1:0]  quo;
  logic [3:0]     qd, q0;
  logic [KW-1:0]  k;
  logic [LZW-1:0] lza, lzb;
  logic           a_zero, b_zero, ge;
  logic [SIG_MAX-1:0] rem_ext, dvs_ext, diff_ext;
  logic [SIG_MAX-RW-1:0] unused_diff_hi;
  int             e;

  dfp_lzc #(.N(N)) u_lza (.sig(sa), .lz(lza));
  dfp_lzc #(.N(N)) u_lzb (.sig(sb), .lz(lzb));

  assign rem_ext        = {{(SIG_MAX - RW){1'b0}}, rem};
  assign dvs_ext        = {{(SIG_MAX - RW){1'b0}}, dvs};
  assign diff_ext       = bcd_sub_n(rem_ext, dvs_ext);
  assign ge             = bcd_ge_n(rem_ext, dvs_ext);
  assign unused_diff_hi = diff_ext[SIG_MAX-1:RW];

  always_comb begin
    a_zero = !a_inf && (a_sig == '0);
    b_zero = !b_inf && (b_sig == '0);
    in_spc = '0;
    if (a_nan || b_nan) begin
      in_spc.special = 1'b1;
      in_spc.nan     = 1'b1;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      in_spc.special = 1'b1;
      in_spc.nan     = 1'b1;
      in_spc.invalid = 1'b1;
    end else if (b_inf) begin
      in_spc.special = 1'b1;
      in_spc.zero    = 1'b1;
    end else if (a_inf) begin
      in_spc.special = 1'b1;
      in_spc.inf     = 1'b1;
    end else if (b_zero) begin
      in_spc.special   = 1'b1;
      in_spc.inf       = 1'b1;
      in_spc.divbyzero = 1'b1;
    end else if (a_zero) begin
      in_spc.special = 1'b1;
      in_spc.zero    = 1'b1;
    end
  end

  // A leading zero quotient digit means the result sits one decade lower.
  always_comb begin
    q0 = quo[QW-1 -: 4];
    e  = int'(ea) - int'(eb) + BIAS - int'(lza) + int'(lzb) - (N + G - 1)
         - ((q0 == 4'd0) ? 1 : 0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      spc      <= '0;
      exc      <= '0;
      sa       <= '0;
      sb       <= '0;
      ea       <= '0;
      eb       <= '0;
      sgn      <= 1'b0;
      rem      <= '0;
      dvs      <= '0;
      quo      <= '0;
      qd       <= '0;
      k        <= '0;
      o_sign   <= 1'b0;
      o_exp    <= '0;
      o_sig    <= '0;
      o_sticky <= 1'b0;
      o_nan    <= 1'b0;
      o_inf    <= 1'b0;
      o_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b1;
    end else if (ce) begin
      if (ld) begin
        sa    <= a_sig;
        sb    <= b_sig;
        ea    <= a_exp;
        eb    <= b_exp;
        sgn   <= a_sign ^ b_sign;
        spc   <= in_spc;
        done  <= 1'b0;
        busy  <= 1'b1;
        state <= in_spc.special ? FIN : NORM;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          NORM: begin
            rem   <= {4'h0, sa << {lza, 2'b00}};
            dvs   <= {4'h0, sb << {lzb, 2'b00}};
            quo   <= '0;
            qd    <= '0;
            k     <= '0;
            state <= DIV;
          end
          DIV: begin
            if (ge) begin
              rem <= diff_ext[RW-1:0];
              qd  <= qd + 4'd1;
            end else begin
              quo <= {quo[QW-5:0], qd};
              rem <= {rem[RW-5:0], 4'h0};
              qd  <= '0;
              k   <= k + 1'b1;
              if (k == KW'(QD - 1)) state <= FIN;
            end
          end
          FIN: begin
            o_sign <= sgn;
            if (spc.special) begin
              o_nan    <= spc.nan;
              o_inf    <= spc.inf;
              o_zero   <= spc.zero;
              o_sig    <= '0;
              o_exp    <= '0;
              o_sticky <= 1'b0;
              exc      <= '{invalid: spc.invalid, divbyzero: spc.divbyzero,
                            overflow: 1'b0, underflow: 1'b0};
            end else begin
              o_nan    <= 1'b0;
              o_inf    <= 1'b0;
              o_zero   <= 1'b0;
              o_sig    <= (q0 == 4'd0) ? quo[OW-1:0] : quo[QW-1:4];
              o_sticky <= (rem != '0) || ((q0 != 4'd0) && (quo[3:0] != 4'd0));
              o_exp    <= (EXPW + 2)'(e);
              exc      <= '{invalid: 1'b0, divbyzero: 1'b0,
                            overflow: (e > ((1 << EXPW) - 1)), underflow: (e < 0)};
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign invalid   = exc.invalid;
  assign divbyzero = exc.divbyzero;
  assign overflow  = exc.overflow;
  assign underflow = exc.underflow;
  assign dbg_state = state;

endmodule

// File: tb/tb_dfp_divide_seq.sv
// Directed bench for dfp_divide_seq: hand-computed quotients, exponents, flags and latencies.
module tb_dfp_divide_seq;
  import dfp_divide_seq_pkg::*;

  localparam int N    = 25;
  localparam int G    = 2;
  localparam int EXPW = 12;
  localparam int BIAS = 'h5FF;
  localparam logic [EXPW-1:0] EB = EXPW'(BIAS);

  logic clk = 1'b0;
  logic rst, ce, ld;
  logic a_sign, b_sign, a_nan, b_nan, a_inf, b_inf;
  logic [EXPW-1:0] a_exp, b_exp;
  logic [N*4-1:0] a_sig, b_sig;
  logic o_sign, o_sticky, o_nan, o_inf, o_zero;
  logic signed [EXPW+1:0] o_exp;
  logic [EXPW+1:0] o_exp_u;
  logic [(N+G)*4-1:0] o_sig;
  logic invalid, divbyzero, overflow, underflow, busy, done;
  dfp_div_state_t dbg_state;

  assign o_exp_u = o_exp;

  dfp_divide_seq #(.N(N), .G(G), .EXPW(EXPW), .BIAS(BIAS)) dut (
    .clk(clk), .rst(rst), .ce(ce), .ld(ld),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_sig(a_sig), .b_sig(b_sig), .a_nan(a_nan), .b_nan(b_nan),
    .a_inf(a_inf), .b_inf(b_inf),
    .o_sign(o_sign), .o_exp(o_exp), .o_sig(o_sig), .o_sticky(o_sticky),
    .o_nan(o_nan), .o_inf(o_inf), .o_zero(o_zero),
    .invalid(invalid), .divbyzero(divbyzero), .overflow(overflow), .underflow(underflow),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [EXPW+1:0] x14(input int v);
    return (EXPW + 2)'(v);
  endfunction

  task automatic issue(input logic as_i, input logic [EXPW-1:0] ae_i, input logic [N*4-1:0] asig_i,
                       input logic an_i, input logic ai_i,
                       input logic bs_i, input logic [EXPW-1:0] be_i, input logic [N*4-1:0] bsig_i,
                       input logic bn_i, input logic bi_i);
    a_sign = as_i; a_exp = ae_i; a_sig = asig_i; a_nan = an_i; a_inf = ai_i;
    b_sign = bs_i; b_exp = be_i; b_sig = bsig_i; b_nan = bn_i; b_inf = bi_i;
    ld = 1'b1;
    tick();
    ld = 1'b0;
  endtask

  task automatic div_plain(input logic as_i, input logic [EXPW-1:0] ae_i, input logic [N*4-1:0] asig_i,
                           input logic bs_i, input logic [EXPW-1:0] be_i, input logic [N*4-1:0] bsig_i);
    issue(as_i, ae_i, asig_i, 1'b0, 1'b0, bs_i, be_i, bsig_i, 1'b0, 1'b0);
  endtask

  // Counts edges after the ld edge until done is seen; bounded so a stuck DUT still reports.
  task automatic wait_done(input int from, output int edges);
    edges = from;
    while (done !== 1'b1 && edges < 2000) begin
      tick();
      edges++;
    end
  endtask

  logic [(N+G)*4-1:0] sig_3, sig_33, sig_1, sig_12;
  int n;
  logic seen;

  initial begin
    sig_3  = {4'h3, {26{4'h0}}};
    sig_33 = {27{4'h3}};
    sig_1  = {4'h1, {26{4'h0}}};
    sig_12 = {4'h1, 4'h2, {25{4'h0}}};

    rst = 1'b1; ce = 1'b1; ld = 1'b0;
    a_sign = 0; b_sign = 0; a_exp = '0; b_exp = '0; a_sig = '0; b_sig = '0;
    a_nan = 0; b_nan = 0; a_inf = 0; b_inf = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    check("rst_done", done, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    check("rst_sig", o_sig, '0);
    check("rst_exp", o_exp_u, '0);
    check("rst_flags", {o_sign, o_sticky, o_nan, o_inf, o_zero, invalid, divbyzero, overflow, underflow}, '0);

    // 6/2
    div_plain(1'b0, EB, 100'h6, 1'b0, EB, 100'h2);
    check("62_busy", busy, 1'b1);
    check("62_done_low", done, 1'b0);
    wait_done(0, n);
    check("62_lat", n, 33);
    check("62_sig", o_sig, sig_3);
    check("62_exp", o_exp_u, x14(BIAS - 26));
    check("62_sticky", o_sticky, 1'b0);
    check("62_busy_end", busy, 1'b0);
    check("62_class", {o_nan, o_inf, o_zero, o_sign}, 4'b0000);

    // 1/3
    div_plain(1'b0, EB, 100'h1, 1'b0, EB, 100'h3);
    wait_done(0, n);
    check("13_lat", n, 111);
    check("13_sig", o_sig, sig_33);
    check("13_exp", o_exp_u, x14(BIAS - 27));
    check("13_sticky", o_sticky, 1'b1);

    // 84/7 with unequal leading zeros, negative divisor
    div_plain(1'b0, EB, 100'h84, 1'b1, EB, 100'h7);
    wait_done(0, n);
    check("847_lat", n, 33);
    check("847_sig", o_sig, sig_12);
    check("847_exp", o_exp_u, x14(BIAS - 25));
    check("847_sign", o_sign, 1'b1);
    check("847_sticky", o_sticky, 1'b0);

    // special cases
    div_plain(1'b0, EB, 100'h0, 1'b0, EB, 100'h0);
    wait_done(0, n);
    check("00_lat", n, 1);
    check("00_nan_inv", {o_nan, invalid, o_inf, o_zero, divbyzero}, 5'b11000);
    check("00_sig", o_sig, '0);

    div_plain(1'b1, EB, 100'h5, 1'b0, EB, 100'h0);
    wait_done(0, n);
    check("50_lat", n, 1);
    check("50_inf_dbz", {o_inf, divbyzero, o_nan, invalid}, 4'b1100);
    check("50_sign", o_sign, 1'b1);

    issue(1'b0, EB, 100'h1, 1'b0, 1'b1, 1'b0, EB, 100'h1, 1'b0, 1'b1);
    wait_done(0, n);
    check("ii_nan_inv", {o_nan, invalid}, 2'b11);

    issue(1'b0, EB, 100'h0, 1'b0, 1'b0, 1'b1, EB, 100'h0, 1'b0, 1'b1);
    wait_done(0, n);
    check("0i_zero", {o_zero, o_inf, o_nan, invalid, divbyzero, o_sign}, 6'b100001);

    issue(1'b0, EB, 100'h7, 1'b1, 1'b0, 1'b0, EB, 100'h0, 1'b0, 1'b0);
    wait_done(0, n);
    check("nan_only", {o_nan, invalid, divbyzero}, 3'b100);

    // restart: 1/3 abandoned at ld+20 by 6/2
    div_plain(1'b0, EB, 100'h1, 1'b0, EB, 100'h3);
    seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    div_plain(1'b0, EB, 100'h6, 1'b0, EB, 100'h2);
    wait_done(0, n);
    check("rs_nodone", seen, 1'b0);
    check("rs_lat", n, 33);
    check("rs_sig", o_sig, sig_3);
    check("rs_sticky", o_sticky, 1'b0);

    // ce held low for 5 cycles during DIV
    div_plain(1'b0, EB, 100'h6, 1'b0, EB, 100'h2);
    for (int i = 0; i < 5; i++) tick();
    ce = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ce_frozen", {done, dbg_state}, {1'b0, DIV});
    ce = 1'b1;
    wait_done(10, n);
    check("ce_lat", n, 38);
    check("ce_sig", o_sig, sig_3);
    check("ce_exp", o_exp_u, x14(BIAS - 26));

    // exponent range
    div_plain(1'b0, '0, 100'h1, 1'b0, {EXPW{1'b1}}, 100'h1);
    wait_done(0, n);
    check("uf_flag", {underflow, overflow}, 2'b10);
    check("uf_exp", o_exp_u, x14(-2586));
    check("uf_sig", o_sig, sig_1);

    div_plain(1'b0, {EXPW{1'b1}}, 100'h1, 1'b0, '0, 100'h1);
    wait_done(0, n);
    check("ov_flag", {underflow, overflow}, 2'b01);
    check("ov_exp", o_exp_u, x14(5604));

    // reset mid-operation
    div_plain(1'b0, EB, 100'h1, 1'b0, EB, 100'h3);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    check("mid_rst", {dbg_state, done, busy, o_sig != '0}, {IDLE, 1'b1, 1'b0, 1'b0});
    tick();
    rst = 1'b0;
    tick();
    div_plain(1'b0, EB, 100'h6, 1'b0, EB, 100'h2);
    wait_done(0, n);
    check("post_rst_lat", n, 33);
    check("post_rst_sig", o_sig, sig_3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dfp_divide_seq.md
# dfp_divide_seq

Parametrised sequential decimal floating-point divider: radix-10 restoring digit recurrence on BCD significands of N digits, with start/done handshake, restart-on-load, operand normalisation, sticky/remainder reporting and full special-case handling. It is the next-generation replacement for the fixed-width 96-bit divider. It sits ahead of the existing DFP normalise/round stages and feeds them an unrounded quotient plus sticky.

## Interface
- N, 25: significand digits per operand.
- G, 2: extra guard digits generated beyond N.
- EXPW, 12: biased exponent width.
- BIAS, 'h5FF: exponent bias.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- ce  in  1  clock enable; low freezes all state and outputs.
- ld  in  1  start; sampled when ce=1.
- a_sign, b_sign  in  1  operand signs.
- a_exp, b_exp  in  EXPW  biased exponents.
- a_sig, b_sig  in  N*4  BCD integer coefficients; value = coeff×10^(exp−BIAS).
- a_nan, b_nan, a_inf, b_inf  in  1  class flags from the unpacker.
- o_sign  out  1  quotient sign.
- o_exp  out  EXPW+2  signed biased exponent, not range-clamped.
- o_sig  out  (N+G)*4  BCD quotient with MS digit nonzero, or zero for zero/inf/NaN.
- o_sticky  out  1  final remainder nonzero.
- o_nan, o_inf, o_zero  out  1  result class.
- invalid, divbyzero, overflow, underflow  out  1  exception flags.
- busy  out  1  operation in progress.
- done  out  1  result valid; level.

## Operation
- States: IDLE, NORM, DIV, FIN.
- IDLE + ld: capture operands, clear done, set busy, go to NORM. A special case goes directly to FIN.
- Special-case priority:
  - any NaN → o_nan=1.
  - 0/0 or inf/inf → o_nan=1, invalid=1.
  - b inf → zero.
  - a inf → inf.
  - b zero → inf, divbyzero=1.
  - a zero → zero.
- o_sign = a_sign^b_sign in every case.
- NORM: left-shift both coefficients so the MS digit is nonzero, using lza and lzb (leading-zero digits). Load partial remainder R = a′ and divisor D = b′. Clear digit counter k and digit register q.
- DIV: each cycle, if R ≥ D then R −= D (BCD) and q++. Otherwise shift q into the quotient, R = R×10 (digit shift), q = 0, k++.
- Generate N+G+1 digits, then go to FIN.
- R needs N+1 digits.
- FIN:
  - If the first quotient digit q0 = 0, o_sig = digits 1..N+G. Otherwise o_sig = digits 0..N+G−1, and the dropped digit ORs into sticky.
  - o_sticky = (R≠0) | dropped digit≠0.
  - o_exp = a_exp − b_exp + BIAS − lza + lzb − (N+G−1) − (q0==0).
  - overflow = o_exp > 2^EXPW−1. underflow = o_exp < 0.
  - Set done, clear busy, go to IDLE.
- ld while busy (NORM/DIV/FIN): abandon the current operation and restart with the new operands. No done pulse is produced for the abandoned one.
- Outputs hold their last result until the next FIN.

## Timing
- Reset values:
  - done=1, busy=0.
  - All o_* outputs and all flags = 0.
  - State IDLE.
- Reset mid-operation returns to IDLE immediately.
- Edge numbering: ld sampled at edge 0.
- Normal path: NORM at edge 1, DIV from edge 2.
- DIV takes C = Σ(d_i+1) cycles over the N+G+1 generated digits. Minimum N+G+1, maximum 10(N+G+1).
- done rises after edge C+2, so latency L = C+3 from ld.
- Special path: FIN at edge 1, done after edge 1, so L=2.
- ce=0 stretches latency cycle-for-cycle.

## Structure
- DFPPkg gains:
  - parametrised BCD helpers: bcd_sub_n, bcd_ge_n.
  - dfp_div_state_t enum.
  - exception-flag struct.
- One sub-module, dfp_lzc: combinational BCD leading-zero-digit counter, parameter N. Instantiated twice in NORM.

## Test plan
- 6/2, both exp=BIAS, N=25, G=2 → o_sig = 3 followed by 26 zeros, o_exp = BIAS−26, sticky=0, C=31, done at ld+34.
- 1/3, exp=BIAS → o_sig = 27 threes, o_exp = BIAS−27, sticky=1, C=109, done at ld+112.
- 0/0 → o_nan=1, invalid=1, done at ld+2. 5/0 → o_inf=1, divbyzero=1.
- ld with 1/3, then ld with 6/2 at ld+20 → only the 6/2 result appears, at second ld+34.
- ce low for 5 cycles during DIV on 6/2 → identical result, done at ld+39.
- a_exp=0, b_exp=2^EXPW−1, coeff 1/1 → underflow=1, negative o_exp.
